// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Glyphs are active-high {g,f,e,d,c,b,a}; polarity is applied at the top.
package sseg_pkg;

  localparam int IDX_W = 2;
  localparam int N_DIG = 4;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] GLYPH_0    = 7'h3F;
  localparam logic [6:0] GLYPH_1    = 7'h06;
  localparam logic [6:0] GLYPH_2    = 7'h5B;
  localparam logic [6:0] GLYPH_3    = 7'h4F;
  localparam logic [6:0] GLYPH_4    = 7'h66;
  localparam logic [6:0] GLYPH_5    = 7'h6D;
  localparam logic [6:0] GLYPH_6    = 7'h7D;
  localparam logic [6:0] GLYPH_7    = 7'h07;
  localparam logic [6:0] GLYPH_8    = 7'h7F;
  localparam logic [6:0] GLYPH_9    = 7'h6F;
  localparam logic [6:0] GLYPH_DASH = 7'(1 << SEG_G);

  localparam logic [7:0] SEG_ALL_OFF = 8'h00;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        colon;
    logic        blank_lz;
    logic [3:0]  blink_mask;
  } snap_t;

  function automatic logic [7:0] seg_pack(
    input logic       dp,
    input logic [6:0] glyph
  );
    logic [7:0] s;
    s         = {1'b0, glyph};
    s[SEG_DP] = dp;
    return s;
  endfunction

endpackage

// File: rtl/sseg_bcd_decode.sv
// BCD nibble to active-high seven-segment glyph.
// Values 10-15 render as a dash.
module sseg_bcd_decode
  import sseg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = GLYPH_DASH;
    unique case (bcd_i)
      4'd0:    glyph_o = GLYPH_0;
      4'd1:    glyph_o = GLYPH_1;
      4'd2:    glyph_o = GLYPH_2;
      4'd3:    glyph_o = GLYPH_3;
      4'd4:    glyph_o = GLYPH_4;
      4'd5:    glyph_o = GLYPH_5;
      4'd6:    glyph_o = GLYPH_6;
      4'd7:    glyph_o = GLYPH_7;
      4'd8:    glyph_o = GLYPH_8;
      4'd9:    glyph_o = GLYPH_9;
      default: glyph_o = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-frame snapshot.
// Define SSEG_COLON_BLINK_EN to gate the colon with the blink phase.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned SCAN_HZ    = 1000,
  parameter int unsigned BLINK_HZ   = 2,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic        M_CLOCK,
  input  logic        M_RESET_N,
  input  logic [15:0] digits_bcd,
  input  logic [3:0]  dp_in,
  input  logic        colon_in,
  input  logic        blank_lz,
  input  logic [3:0]  blink_mask,
  output logic [7:0]  IO_SSEG,
  output logic [3:0]  IO_SSEGD,
  output logic        IO_SSEG_COL,
  output logic        frame_start
);

  localparam bit AL = (ACTIVE_LOW != 0);

  localparam int unsigned PRE_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PRE_W   =
    (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX =
    PRE_W'(PRE_DIV - 1);

  localparam int unsigned BLK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned BLK_W   =
    (BLK_DIV > 1) ? $clog2(BLK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX =
    BLK_W'(BLK_DIV - 1);

  localparam logic [7:0] SEG_RST = AL ? ~SEG_ALL_OFF : SEG_ALL_OFF;
  localparam logic [3:0] AN_RST  = AL ? 4'hF : 4'h0;
  localparam logic       COL_RST = AL;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             phase_q, phase_d;
  snap_t            snap_q, snap_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             col_q, col_d;

  logic             tick;
  logic             wrap;
  logic             blk_term;
  logic [3:0]       cur_val;
  logic [6:0]       glyph;
  logic             lz_hit;
  logic             blink_hit;
  logic [7:0]       seg_on;
  logic [3:0]       an_on;
  logic             col_on;

  assign tick     = (pre_q == PRE_MAX);
  assign wrap     = tick && (idx_q == '1);
  assign blk_term = (blk_q == BLK_MAX);
  assign cur_val  = snap_q.digits[{idx_q, 2'b00} +: 4];

  sseg_bcd_decode u_dec (
    .bcd_i   (cur_val),
    .glyph_o (glyph)
  );

  // Blanked digits keep their anode so brightness stays uniform.
  always_comb begin
    lz_hit    = snap_q.blank_lz
             && (idx_q == IDX_W'(N_DIG - 1))
             && (cur_val == 4'd0);
    blink_hit = phase_q && snap_q.blink_mask[idx_q];
    seg_on    = SEG_ALL_OFF;
    if (!(lz_hit || blink_hit)) begin
      seg_on = seg_pack(snap_q.dp[idx_q], glyph);
    end
    an_on = 4'b0001 << idx_q;
`ifdef SSEG_COLON_BLINK_EN
    col_on = snap_q.colon && !phase_q;
`else
    col_on = snap_q.colon;
`endif
  end

  always_comb begin
    pre_d   = tick ? '0 : pre_q + PRE_W'(1);
    idx_d   = tick ? idx_q + IDX_W'(1) : idx_q;
    blk_d   = blk_term ? '0 : blk_q + BLK_W'(1);
    phase_d = phase_q ^ blk_term;
    snap_d  = snap_q;
    seg_d   = seg_q;
    an_d    = an_q;
    col_d   = col_q;
    if (wrap) begin
      snap_d.digits     = digits_bcd;
      snap_d.dp         = dp_in;
      snap_d.colon      = colon_in;
      snap_d.blank_lz   = blank_lz;
      snap_d.blink_mask = blink_mask;
    end
    if (tick) begin
      seg_d = AL ? ~seg_on : seg_on;
      an_d  = AL ? ~an_on  : an_on;
      col_d = AL ? ~col_on : col_on;
    end
  end

  always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
    if (!M_RESET_N) begin
      pre_q   <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b0;
      snap_q  <= '0;
      seg_q   <= SEG_RST;
      an_q    <= AN_RST;
      col_q   <= COL_RST;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      col_q   <= col_d;
    end
  end

  assign IO_SSEG     = seg_q;
  assign IO_SSEGD    = an_q;
  assign IO_SSEG_COL = col_q;
  assign frame_start = wrap;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: cycle-count model plus directed literals.
// 10-clock scan tick, 20-clock blink half-period.
module tb_sseg_scan_driver;

  logic        M_CLOCK    = 1'b0;
  logic        M_RESET_N  = 1'b0;
  logic [15:0] digits_bcd = 16'h0;
  logic [3:0]  dp_in      = 4'h0;
  logic        colon_in   = 1'b0;
  logic        blank_lz   = 1'b0;
  logic [3:0]  blink_mask = 4'h0;
  logic [7:0]  IO_SSEG;
  logic [3:0]  IO_SSEGD;
  logic        IO_SSEG_COL;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  always #5 M_CLOCK = ~M_CLOCK;

  sseg_scan_driver #(
    .CLK_HZ     (1000),
    .SCAN_HZ    (100),
    .BLINK_HZ   (25),
    .ACTIVE_LOW (1)
  ) dut (
    .M_CLOCK     (M_CLOCK),
    .M_RESET_N   (M_RESET_N),
    .digits_bcd  (digits_bcd),
    .dp_in       (dp_in),
    .colon_in    (colon_in),
    .blank_lz    (blank_lz),
    .blink_mask  (blink_mask),
    .IO_SSEG     (IO_SSEG),
    .IO_SSEGD    (IO_SSEGD),
    .IO_SSEG_COL (IO_SSEG_COL),
    .frame_start (frame_start)
  );

  logic [6:0] glyph_tab [16];
  initial begin
    glyph_tab[0] = 7'h3F; glyph_tab[1] = 7'h06;
    glyph_tab[2] = 7'h5B; glyph_tab[3] = 7'h4F;
    glyph_tab[4] = 7'h66; glyph_tab[5] = 7'h6D;
    glyph_tab[6] = 7'h7D; glyph_tab[7] = 7'h07;
    glyph_tab[8] = 7'h7F; glyph_tab[9] = 7'h6F;
    for (int i = 10; i < 16; i++) glyph_tab[i] = 7'h40;
  end

  // Model: n = clock edges since reset release.
  // Tick j lands on edge 10j, shows digit (j-1)%4, phase (n/20)%2.
  int          n      = 0;
  int          m_j    = 0;
  int          m_d    = 0;
  int          m_ph   = 0;
  logic [15:0] m_dig  = 16'h0;
  logic [3:0]  m_dp   = 4'h0;
  logic [3:0]  m_mask = 4'h0;
  logic        m_col  = 1'b0;
  logic        m_lz   = 1'b0;
  logic [3:0]  m_v;
  logic        m_blank;
  logic [7:0]  m_on;
  logic [7:0]  e_seg  = 8'hFF;
  logic [3:0]  e_an   = 4'hF;
  logic        e_col  = 1'b1;
  logic        e_fs;

  always @(posedge M_CLOCK or negedge M_RESET_N) begin
    if (!M_RESET_N) begin
      n = 0;
      m_dig = 16'h0; m_dp = 4'h0; m_mask = 4'h0;
      m_col = 1'b0;  m_lz = 1'b0;
      e_seg = 8'hFF; e_an = 4'hF; e_col = 1'b1;
    end else begin
      if (n % 10 == 9) begin
        m_j  = (n + 1) / 10;
        m_d  = (m_j - 1) % 4;
        m_ph = (n / 20) % 2;
        m_v  = m_dig[4*m_d +: 4];
        m_blank = (m_d == 3 && m_lz && m_v == 4'd0)
               || (m_ph == 1 && m_mask[m_d]);
        m_on  = m_blank ? 8'h00 : {m_dp[m_d], glyph_tab[m_v]};
        e_seg = ~m_on;
        e_an  = ~(4'b0001 << m_d);
`ifdef SSEG_COLON_BLINK_EN
        e_col = ~(m_col && m_ph == 0);
`else
        e_col = ~m_col;
`endif
        if (m_j % 4 == 0) begin
          m_dig = digits_bcd; m_dp = dp_in; m_mask = blink_mask;
          m_col = colon_in;   m_lz = blank_lz;
        end
      end
      n = n + 1;
    end
  end

  always @(negedge M_CLOCK) begin
    e_fs = M_RESET_N && (n % 10 == 9) && ((n / 10) % 4 == 3);
    checks++;
    if (IO_SSEG !== e_seg || IO_SSEGD !== e_an ||
        IO_SSEG_COL !== e_col || frame_start !== e_fs) begin
      failures++;
      if (failures <= 20)
        $display("FAIL model t=%0t seg got=%h want=%h an got=%b want=%b col got=%b want=%b fs got=%b want=%b",
                 $time, IO_SSEG, e_seg, IO_SSEGD, e_an,
                 IO_SSEG_COL, e_col, frame_start, e_fs);
    end
  end

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge M_CLOCK);
  endtask

  task automatic wait_frame(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge M_CLOCK);
      if (frame_start === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s frame_start got=0 want=1", name);
    end
  endtask

  // Colon lit on first two ticks of a frame when blink-gated.
  function automatic logic col_want(input int d);
`ifdef SSEG_COLON_BLINK_EN
    return (d >= 2);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_digit(input string name, input int d,
                           input logic [7:0] seg);
    logic [3:0] an;
    an = ~(4'b0001 << d);
    chk({name, "_an"},  {4'h0, IO_SSEGD}, {4'h0, an});
    chk({name, "_seg"}, IO_SSEG, seg);
    chk({name, "_col"}, {7'h0, IO_SSEG_COL}, {7'h0, col_want(d)});
  endtask

  initial begin
    step(3);
    chk("rst_seg", IO_SSEG, 8'hFF);
    chk("rst_an",  {4'h0, IO_SSEGD}, 8'h0F);
    chk("rst_col", {7'h0, IO_SSEG_COL}, 8'h01);
    chk("rst_fs",  {7'h0, frame_start}, 8'h00);

    digits_bcd = 16'h1234;
    colon_in   = 1'b1;
    M_RESET_N  = 1'b1;
    step(9);
    chk("pre_tick_an", {4'h0, IO_SSEGD}, 8'h0F);
    step(1);
    chk("first_an",  {4'h0, IO_SSEGD}, 8'h0E);
    chk("first_seg", IO_SSEG, 8'hC0);

    wait_frame("frame1");
    step(11); chk_digit("s_d0", 0, ~8'h66);
    step(10); chk_digit("s_d1", 1, ~8'h4F);
    digits_bcd = 16'h5678;
    step(10); chk_digit("tear_d2", 2, ~8'h5B);
    step(10); chk_digit("tear_d3", 3, ~8'h06);
    step(10); chk_digit("new_d0", 0, ~8'h7F);
    step(10); chk_digit("new_d1", 1, ~8'h07);

    digits_bcd = 16'h0930;
    blank_lz   = 1'b1;
    blink_mask = 4'b0101;
    wait_frame("frame_blank");
    step(11); chk_digit("b_d0", 0, ~8'h3F);
    step(10); chk_digit("b_d1", 1, ~8'h4F);
    step(10); chk_digit("b_d2", 2, 8'hFF);
    step(10); chk_digit("b_d3", 3, 8'hFF);

    digits_bcd = 16'h09A0;
    blank_lz   = 1'b0;
    dp_in      = 4'b1100;
    blink_mask = 4'b0100;
    wait_frame("frame_dash");
    step(11); chk_digit("x_d0", 0, ~8'h3F);
    step(10); chk_digit("x_d1", 1, ~8'h40);
    step(10); chk_digit("x_d2", 2, 8'hFF);
    step(10); chk_digit("x_d3", 3, ~8'hBF);

    step(3);
    #2 M_RESET_N = 1'b0;
    #1;
    chk("mid_rst_seg", IO_SSEG, 8'hFF);
    chk("mid_rst_an",  {4'h0, IO_SSEGD}, 8'h0F);
    chk("mid_rst_col", {7'h0, IO_SSEG_COL}, 8'h01);
    chk("mid_rst_fs",  {7'h0, frame_start}, 8'h00);
    step(2);
    M_RESET_N = 1'b1;
    step(10);
    chk("rerst_an",  {4'h0, IO_SSEGD}, 8'h0E);
    chk("rerst_seg", IO_SSEG, 8'hC0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
